// File: rtl/sfq_xor_driver_if.sv
// Operand handshake, SFQ pulse lines, cell readback and result reporting
// for the SFQ XOR cell stimulus driver.
interface sfq_xor_driver_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_a;
    logic       in_b;
    logic       a_out;
    logic       b_out;
    logic       sclk_out;
    logic       out_in;
    logic       res_valid;
    logic       res_bit;
    logic       res_err;
    logic [7:0] err_cnt;
    logic       busy;

    modport master (
        output in_valid, in_a, in_b, out_in,
        input  in_ready, a_out, b_out, sclk_out, res_valid, res_bit, res_err, err_cnt, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_in,
        output in_ready, a_out, b_out, sclk_out, res_valid, res_bit, res_err, err_cnt, busy
    );
endinterface

// File: rtl/sfq_xor_driver.sv
// Encodes an operand pair as SFQ toggles on a/b, clocks the XOR cell, then
// decodes the cell's toggling output against a reference captured at the clock pulse.
module sfq_xor_driver #(
    parameter int AB_GAP    = 2,
    parameter int SETUP_CYC = 2,
    parameter int LAT_CYC   = 4,
    parameter int HOLD_CYC  = 3
) (
    input  logic            clk,
    input  logic            rst,
    sfq_xor_driver_if.slave bus
);
    localparam int CW = 8;

    typedef enum logic [2:0] {
        IDLE, SEND_A, GAP_AB, SEND_B, SETUP, SEND_CLK, WAIT_OUT, HOLD
    } state_t;

    // Zero-length timed states are skipped entirely.
    localparam state_t POST_DATA = (SETUP_CYC == 0) ? SEND_CLK : SETUP;
    localparam state_t AFTER_A_B = (AB_GAP == 0)    ? SEND_B   : GAP_AB;

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic          op_a, op_b;
    logic          sync1, sync2, out_ref;
    logic          dec_bit, dec_err;

    assign dec_bit = sync2 ^ out_ref;
    assign dec_err = dec_bit ^ (op_a ^ op_b);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:     if (bus.in_valid && bus.in_ready)
                          nxt = bus.in_a ? SEND_A : (bus.in_b ? SEND_B : POST_DATA);
            SEND_A:   nxt = op_b ? AFTER_A_B : POST_DATA;
            GAP_AB:   if (cnt == '0) nxt = SEND_B;
            SEND_B:   nxt = POST_DATA;
            SETUP:    if (cnt == '0) nxt = SEND_CLK;
            SEND_CLK: nxt = WAIT_OUT;
            WAIT_OUT: if (cnt == '0) nxt = HOLD;
            HOLD:     if (cnt == '0) nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // Entry actions are keyed on the state being entered so every pulse and
    // strobe appears one cycle after the decision, fully registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            op_a          <= 1'b0;
            op_b          <= 1'b0;
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            out_ref       <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.a_out     <= 1'b0;
            bus.b_out     <= 1'b0;
            bus.sclk_out  <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_bit   <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.err_cnt   <= '0;
        end else begin
            sync1         <= bus.out_in;
            sync2         <= sync1;
            state         <= nxt;
            bus.in_ready  <= (nxt == IDLE);
            bus.busy      <= (nxt != IDLE);
            bus.res_valid <= 1'b0;
            if (cnt != '0) cnt <= cnt - 1'b1;
            if (state == IDLE && nxt != IDLE) begin
                op_a <= bus.in_a;
                op_b <= bus.in_b;
            end
            if (nxt != state) begin
                case (nxt)
                    SEND_A:   bus.a_out <= ~bus.a_out;
                    GAP_AB:   cnt <= CW'(AB_GAP - 1);
                    SEND_B:   bus.b_out <= ~bus.b_out;
                    SETUP:    cnt <= CW'(SETUP_CYC - 1);
                    SEND_CLK: begin
                        bus.sclk_out <= ~bus.sclk_out;
                        out_ref      <= sync2;
                    end
                    WAIT_OUT: cnt <= CW'(LAT_CYC - 1);
                    HOLD: begin
                        cnt           <= CW'(HOLD_CYC - 1);
                        bus.res_valid <= 1'b1;
                        bus.res_bit   <= dec_bit;
                        bus.res_err   <= dec_err;
                        if (dec_err && bus.err_cnt != 8'hFF)
                            bus.err_cnt <= bus.err_cnt + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sfq_xor_driver.sv
// Directed bench for sfq_xor_driver: cycle-exact pulse timing, decode and error counting.
module tb_sfq_xor_driver;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sfq_xor_driver_if bus();
    sfq_xor_driver dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    int exp_err = 0;
    int a_c, b_c, s_c, na, nb, ns, rv_c, nrv, rdy_c;
    logic rbit, rerr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction; cycle 1 is the sample right after the accept edge.
    // t1/t2 (>0) toggle out_in that many cycles after the sclk toggle is seen.
    task automatic run_txn(input logic a, input logic b, input int t1, input int t2);
        int w;
        logic pa, pb, ps;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin step(); w++; end
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ready_timeout: got %b want 1", bus.in_ready); end
        pa = bus.a_out; pb = bus.b_out; ps = bus.sclk_out;
        a_c = -1; b_c = -1; s_c = -1; rv_c = -1; rdy_c = -1;
        na = 0; nb = 0; ns = 0; nrv = 0; rbit = 1'bx; rerr = 1'bx;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        step();
        bus.in_valid = 1'b0; bus.in_a = ~a; bus.in_b = ~b;
        for (int c = 1; c <= 40; c++) begin
            if (bus.a_out !== pa) begin na++; if (a_c < 0) a_c = c; pa = bus.a_out; end
            if (bus.b_out !== pb) begin nb++; if (b_c < 0) b_c = c; pb = bus.b_out; end
            if (bus.sclk_out !== ps) begin ns++; if (s_c < 0) s_c = c; ps = bus.sclk_out; end
            if (bus.res_valid === 1'b1) begin nrv++; rv_c = c; rbit = bus.res_bit; rerr = bus.res_err; end
            if (bus.in_ready === 1'b1 && rdy_c < 0) rdy_c = c;
            if (s_c >= 0 && t1 > 0 && c == s_c + t1) bus.out_in = ~bus.out_in;
            if (s_c >= 0 && t2 > 0 && c == s_c + t2) bus.out_in = ~bus.out_in;
            if (rdy_c >= 0) break;
            step();
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_a = 1'b0; bus.in_b = 1'b0; bus.out_in = 1'b0;
        #2 rst = 1'b1;
        step(); step();
        total++; if ({bus.a_out, bus.b_out, bus.sclk_out} !== 3'b000) begin bad++; $display("FAIL rst_pulse_lines: got %b want 000", {bus.a_out, bus.b_out, bus.sclk_out}); end
        total++; if ({bus.in_ready, bus.busy, bus.res_valid, bus.res_bit, bus.res_err} !== 5'b0) begin bad++; $display("FAIL rst_status: got %b want 00000", {bus.in_ready, bus.busy, bus.res_valid, bus.res_bit, bus.res_err}); end
        total++; if (bus.err_cnt !== 8'd0) begin bad++; $display("FAIL rst_err_cnt: got %0d want 0", bus.err_cnt); end
        @(negedge clk) rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_early: got %b want 0", bus.in_ready); end
        step();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_rise: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_one_zero();
        run_txn(1'b1, 1'b0, 2, 0);
        total++; if (a_c != 1 || na != 1 || nb != 0) begin bad++; $display("FAIL t10_a_pulse: a_c=%0d na=%0d nb=%0d want 1 1 0", a_c, na, nb); end
        total++; if (s_c != 4 || ns != 1) begin bad++; $display("FAIL t10_sclk: s_c=%0d ns=%0d want 4 1", s_c, ns); end
        total++; if (rv_c != 9 || nrv != 1) begin bad++; $display("FAIL t10_res_valid: rv_c=%0d nrv=%0d want 9 1", rv_c, nrv); end
        total++; if (rbit !== 1'b1 || rerr !== 1'b0) begin bad++; $display("FAIL t10_result: bit=%b err=%b want 1 0", rbit, rerr); end
        total++; if (rdy_c != 12) begin bad++; $display("FAIL t10_ready: got %0d want 12", rdy_c); end
        total++; if (bus.res_bit !== 1'b1) begin bad++; $display("FAIL t10_bit_hold: got %b want 1", bus.res_bit); end
    endtask

    task automatic test_one_one();
        run_txn(1'b1, 1'b1, 0, 0);
        total++; if (a_c != 1 || b_c != 4 || na != 1 || nb != 1) begin bad++; $display("FAIL t11_ab: a_c=%0d b_c=%0d na=%0d nb=%0d want 1 4 1 1", a_c, b_c, na, nb); end
        total++; if (s_c != 7 || rv_c != 12 || rdy_c != 15) begin bad++; $display("FAIL t11_timing: s=%0d rv=%0d rdy=%0d want 7 12 15", s_c, rv_c, rdy_c); end
        total++; if (rbit !== 1'b0 || rerr !== 1'b0) begin bad++; $display("FAIL t11_result: bit=%b err=%b want 0 0", rbit, rerr); end
        total++; if (bus.err_cnt !== 8'(exp_err)) begin bad++; $display("FAIL t11_err_cnt: got %0d want %0d", bus.err_cnt, exp_err); end
    endtask

    task automatic test_double_toggle();
        run_txn(1'b1, 1'b0, 1, 2);
        exp_err++;
        total++; if (rbit !== 1'b0 || rerr !== 1'b1) begin bad++; $display("FAIL dbl_result: bit=%b err=%b want 0 1", rbit, rerr); end
        total++; if (bus.err_cnt !== 8'(exp_err)) begin bad++; $display("FAIL dbl_err_cnt: got %0d want %0d", bus.err_cnt, exp_err); end
    endtask

    task automatic test_back_to_back();
        int c;
        int w;
        logic pa, pb, ps;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin step(); w++; end
        pa = bus.a_out; pb = bus.b_out; ps = bus.sclk_out;
        na = 0; nb = 0; ns = 0; nrv = 0; rbit = 1'bx; rerr = 1'bx;
        bus.in_valid = 1'b1; bus.in_a = 1'b0; bus.in_b = 1'b0;
        step();
        bus.in_a = 1'b1;
        c = 0;
        while (c < 40) begin
            c++;
            if (bus.a_out !== pa) begin na++; pa = bus.a_out; end
            if (bus.b_out !== pb) begin nb++; pb = bus.b_out; end
            if (bus.sclk_out !== ps) begin ns++; ps = bus.sclk_out; end
            if (bus.res_valid === 1'b1) begin nrv++; rbit = bus.res_bit; rerr = bus.res_err; end
            if (bus.in_ready === 1'b1) break;
            step();
        end
        total++; if (c != 11) begin bad++; $display("FAIL b2b_accept_gap: got %0d want 11", c); end
        total++; if (na != 0 || nb != 0 || ns != 1) begin bad++; $display("FAIL b2b_edges: na=%0d nb=%0d ns=%0d want 0 0 1", na, nb, ns); end
        total++; if (nrv != 1 || rbit !== 1'b0 || rerr !== 1'b0) begin bad++; $display("FAIL b2b_first_res: nrv=%0d bit=%b err=%b want 1 0 0", nrv, rbit, rerr); end
        step();
        bus.in_valid = 1'b0;
        total++; if (bus.a_out === pa || bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept: a=%b busy=%b want %b 1", bus.a_out, bus.busy, ~pa); end
        w = 0;
        while (bus.res_valid !== 1'b1 && w < 40) begin step(); w++; end
        exp_err++;
        total++; if (bus.res_valid !== 1'b1 || bus.res_bit !== 1'b0 || bus.res_err !== 1'b1) begin bad++; $display("FAIL b2b_second_res: v=%b bit=%b err=%b want 1 0 1", bus.res_valid, bus.res_bit, bus.res_err); end
        total++; if (bus.err_cnt !== 8'(exp_err)) begin bad++; $display("FAIL b2b_err_cnt: got %0d want %0d", bus.err_cnt, exp_err); end
    endtask

    task automatic test_reset_mid();
        int w;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin step(); w++; end
        bus.in_valid = 1'b1; bus.in_a = 1'b1; bus.in_b = 1'b0;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #2 rst = 1'b1;
        #1;
        total++; if ({bus.a_out, bus.b_out, bus.sclk_out} !== 3'b000) begin bad++; $display("FAIL mid_rst_lines: got %b want 000", {bus.a_out, bus.b_out, bus.sclk_out}); end
        total++; if ({bus.in_ready, bus.busy, bus.res_valid} !== 3'b000 || bus.err_cnt !== 8'd0) begin bad++; $display("FAIL mid_rst_status: rdy/busy/v=%b cnt=%0d want 000 0", {bus.in_ready, bus.busy, bus.res_valid}, bus.err_cnt); end
        bus.out_in = 1'b0;
        step(); step();
        total++; if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_held: v=%b rdy=%b want 0 0", bus.res_valid, bus.in_ready); end
        @(negedge clk) rst = 1'b0;
        exp_err = 0;
        step();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", bus.in_ready); end
        run_txn(1'b1, 1'b0, 2, 0);
        total++; if (rv_c != 9 || rbit !== 1'b1 || rerr !== 1'b0 || bus.err_cnt !== 8'd0) begin bad++; $display("FAIL mid_rst_next: rv=%0d bit=%b err=%b cnt=%0d want 9 1 0 0", rv_c, rbit, rerr, bus.err_cnt); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            run_txn(1'b0, 1'b1, 0, 0);
            if (i == 0) begin
                total++; if (rv_c != 9 || rbit !== 1'b0 || rerr !== 1'b1) begin bad++; $display("FAIL sat_first: rv=%0d bit=%b err=%b want 9 0 1", rv_c, rbit, rerr); end
                total++; if (bus.err_cnt !== 8'd1) begin bad++; $display("FAIL sat_cnt1: got %0d want 1", bus.err_cnt); end
            end
            if (i == 253) begin
                total++; if (bus.err_cnt !== 8'd254) begin bad++; $display("FAIL sat_cnt254: got %0d want 254", bus.err_cnt); end
            end
            if (i == 254 || i == 299) begin
                total++; if (bus.err_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt255: iter=%0d got %0d want 255", i, bus.err_cnt); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_zero();
        test_one_one();
        test_double_toggle();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
